// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - shared op encodings, widths and helpers for the memory-access stage
package mem_access_pkg;

    localparam int BUS_W     = 32;
    localparam int BE_W      = BUS_W / 8;
    localparam int TMO_CNT_W = 8;

    typedef enum logic [3:0] {
        MEM_NOP = 4'd0,
        MEM_LB  = 4'd1,
        MEM_LH  = 4'd2,
        MEM_LW  = 4'd3,
        MEM_LBU = 4'd4,
        MEM_LHU = 4'd5,
        MEM_SB  = 4'd6,
        MEM_SH  = 4'd7,
        MEM_SW  = 4'd8
    } mem_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUS  = 1'b1
    } state_e;

    function automatic logic is_store(input mem_op_e op);
        return op inside {MEM_SB, MEM_SH, MEM_SW};
    endfunction

    function automatic logic is_misaligned(input mem_op_e op, input logic [1:0] lo);
        return ((op inside {MEM_LH, MEM_LHU, MEM_SH}) && lo[0]) ||
               ((op inside {MEM_LW, MEM_SW}) && (lo != 2'b00));
    endfunction

endpackage

// File: rtl/mem_lane.sv
// rtl/mem_lane.sv - store lane placement / byte enables and load extraction / extension
module mem_lane
    import mem_access_pkg::*;
(
    input  mem_op_e           st_op_i,
    input  logic [1:0]        st_lo_i,
    input  logic [BUS_W-1:0]  st_data_i,
    output logic [BE_W-1:0]   be_o,
    output logic [BUS_W-1:0]  wdata_o,
    input  mem_op_e           ld_op_i,
    input  logic [1:0]        ld_lo_i,
    input  logic [BUS_W-1:0]  rdata_i,
    output logic [BUS_W-1:0]  ld_data_o
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        be_o    = '0;
        wdata_o = '0;
        case (st_op_i)
            MEM_LB, MEM_LBU: be_o = 4'b0001 << st_lo_i;
            MEM_SB: begin
                be_o    = 4'b0001 << st_lo_i;
                wdata_o = {4{st_data_i[7:0]}};
            end
            MEM_LH, MEM_LHU: be_o = st_lo_i[1] ? 4'b1100 : 4'b0011;
            MEM_SH: begin
                be_o    = st_lo_i[1] ? 4'b1100 : 4'b0011;
                wdata_o = {2{st_data_i[15:0]}};
            end
            MEM_LW: be_o = 4'b1111;
            MEM_SW: begin
                be_o    = 4'b1111;
                wdata_o = st_data_i;
            end
            default: ;
        endcase
    end

    always_comb begin
        case (ld_lo_i)
            2'd0:    ld_byte = rdata_i[7:0];
            2'd1:    ld_byte = rdata_i[15:8];
            2'd2:    ld_byte = rdata_i[23:16];
            default: ld_byte = rdata_i[31:24];
        endcase
        ld_half = ld_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

        case (ld_op_i)
            MEM_LB:  ld_data_o = {{24{ld_byte[7]}}, ld_byte};
            MEM_LBU: ld_data_o = {24'd0, ld_byte};
            MEM_LH:  ld_data_o = {{16{ld_half[15]}}, ld_half};
            MEM_LHU: ld_data_o = {16'd0, ld_half};
            MEM_LW:  ld_data_o = rdata_i;
            default: ld_data_o = '0;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// rtl/mem_access.sv - memory-access pipeline stage: bus FSM, timeout counter, registered writeback
module mem_access
    import mem_access_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [4:0]            reg_waddr_i,
    input  logic                  reg_we_i,
    input  logic [DATA_WIDTH-1:0] reg_wdata_i,
    input  logic [ADDR_WIDTH-1:0] mem_addr_i,
    input  logic [DATA_WIDTH-1:0] mem_data_i,
    input  logic                  mem_we_i,
    input  logic [3:0]            mem_op_i,
    output logic                  bus_req_o,
    output logic                  bus_we_o,
    output logic [ADDR_WIDTH-1:0] bus_addr_o,
    output logic [DATA_WIDTH-1:0] bus_wdata_o,
    output logic [3:0]            bus_be_o,
    input  logic                  bus_ack_i,
    input  logic [DATA_WIDTH-1:0] bus_rdata_i,
    output logic [4:0]            reg_waddr_o,
    output logic                  reg_we_o,
    output logic [DATA_WIDTH-1:0] reg_wdata_o,
    output logic                  stallreq_o,
    output logic                  misalign_o,
    output logic                  timeout_o
);

    // The op code alone decides direction; the execute-side store flag is redundant here.
    logic unused_mem_we;
    assign unused_mem_we = mem_we_i;

    state_e                 state_q, state_d;
    logic [TMO_CNT_W-1:0]   cnt_q, cnt_d;
    mem_op_e                op_q, op_d;
    logic [1:0]             lo_q, lo_d;
    logic [4:0]             dest_q, dest_d;
    logic                   bus_req_q, bus_req_d, bus_we_q, bus_we_d;
    logic [ADDR_WIDTH-1:0]  bus_addr_q, bus_addr_d;
    logic [DATA_WIDTH-1:0]  bus_wdata_q, bus_wdata_d;
    logic [3:0]             bus_be_q, bus_be_d;
    logic [4:0]             reg_waddr_q, reg_waddr_d;
    logic                   reg_we_q, reg_we_d;
    logic [DATA_WIDTH-1:0]  reg_wdata_q, reg_wdata_d;
    logic                   misalign_q, misalign_d, timeout_q, timeout_d;
    logic                   stall;

    mem_op_e               op_in;
    logic                  op_valid, cnt_at_max;
    logic [3:0]            st_be;
    logic [DATA_WIDTH-1:0] st_wdata, ld_data;

    assign op_in      = mem_op_e'(mem_op_i);
    assign op_valid   = mem_op_i inside {[4'd1:4'd8]};
    assign cnt_at_max = (cnt_q == TMO_CNT_W'(TIMEOUT_CYCLES));

    mem_lane u_lane (
        .st_op_i   (op_in),
        .st_lo_i   (mem_addr_i[1:0]),
        .st_data_i (mem_data_i),
        .be_o      (st_be),
        .wdata_o   (st_wdata),
        .ld_op_i   (op_q),
        .ld_lo_i   (lo_q),
        .rdata_i   (bus_rdata_i),
        .ld_data_o (ld_data)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        lo_d        = lo_q;
        dest_d      = dest_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_be_d    = bus_be_q;
        reg_waddr_d = reg_waddr_q;
        reg_we_d    = 1'b0;
        reg_wdata_d = reg_wdata_q;
        misalign_d  = 1'b0;
        timeout_d   = 1'b0;
        stall       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!op_valid) begin
                    reg_waddr_d = reg_waddr_i;
                    reg_we_d    = reg_we_i;
                    reg_wdata_d = reg_wdata_i;
                end else if (is_misaligned(op_in, mem_addr_i[1:0])) begin
                    misalign_d = 1'b1;
                end else begin
                    stall       = 1'b1;
                    op_d        = op_in;
                    lo_d        = mem_addr_i[1:0];
                    dest_d      = reg_waddr_i;
                    bus_req_d   = 1'b1;
                    bus_we_d    = is_store(op_in);
                    bus_addr_d  = {mem_addr_i[ADDR_WIDTH-1:2], 2'b00};
                    bus_be_d    = st_be;
                    bus_wdata_d = st_wdata;
                    cnt_d       = '0;
                    state_d     = ST_BUS;
                end
            end
            ST_BUS: begin
                stall = !bus_ack_i && !cnt_at_max;
                cnt_d = cnt_q + 1'b1;
                // Ack takes priority over a simultaneous timeout.
                if (bus_ack_i || cnt_at_max) begin
                    state_d     = ST_IDLE;
                    bus_req_d   = 1'b0;
                    bus_we_d    = 1'b0;
                    bus_addr_d  = '0;
                    bus_wdata_d = '0;
                    bus_be_d    = '0;
                    if (bus_ack_i) begin
                        if (!is_store(op_q)) begin
                            reg_we_d    = 1'b1;
                            reg_waddr_d = dest_q;
                            reg_wdata_d = ld_data;
                        end
                    end else begin
                        timeout_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            op_q        <= MEM_NOP;
            lo_q        <= '0;
            dest_q      <= '0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_be_q    <= '0;
            reg_waddr_q <= '0;
            reg_we_q    <= 1'b0;
            reg_wdata_q <= '0;
            misalign_q  <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            lo_q        <= lo_d;
            dest_q      <= dest_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_be_q    <= bus_be_d;
            reg_waddr_q <= reg_waddr_d;
            reg_we_q    <= reg_we_d;
            reg_wdata_q <= reg_wdata_d;
            misalign_q  <= misalign_d;
            timeout_q   <= timeout_d;
        end
    end

    assign bus_req_o   = bus_req_q;
    assign bus_we_o    = bus_we_q;
    assign bus_addr_o  = bus_addr_q;
    assign bus_wdata_o = bus_wdata_q;
    assign bus_be_o    = bus_be_q;
    assign reg_waddr_o = reg_waddr_q;
    assign reg_we_o    = reg_we_q;
    assign reg_wdata_o = reg_wdata_q;
    assign misalign_o  = misalign_q;
    assign timeout_o   = timeout_q;
    assign stallreq_o  = stall;

endmodule

// File: tb/tb_mem_access.sv
// tb/tb_mem_access.sv - directed self-checking bench with writeback scoreboard for mem_access
module tb_mem_access;

    localparam logic [3:0] OP_NOP = 4'd0, OP_LB = 4'd1, OP_LH = 4'd2, OP_LW = 4'd3,
                           OP_LBU = 4'd4, OP_LHU = 4'd5, OP_SB = 4'd6, OP_SH = 4'd7,
                           OP_SW = 4'd8;

    typedef struct {
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } wb_t;

    logic        clk_i, rst_i;
    logic [4:0]  reg_waddr_i;
    logic        reg_we_i;
    logic [31:0] reg_wdata_i, mem_addr_i, mem_data_i;
    logic        mem_we_i;
    logic [3:0]  mem_op_i;
    logic        bus_req_o, bus_we_o;
    logic [31:0] bus_addr_o, bus_wdata_o;
    logic [3:0]  bus_be_o;
    logic        bus_ack_i;
    logic [31:0] bus_rdata_i;
    logic [4:0]  reg_waddr_o;
    logic        reg_we_o;
    logic [31:0] reg_wdata_o;
    logic        stallreq_o, misalign_o, timeout_o;

    int n_assert = 0;
    int n_fail   = 0;
    wb_t sb_q[$];

    logic [3:0]  cur_op;
    logic [31:0] cur_addr;
    logic [4:0]  cur_dest;

    mem_access #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .reg_waddr_i(reg_waddr_i), .reg_we_i(reg_we_i), .reg_wdata_i(reg_wdata_i),
        .mem_addr_i(mem_addr_i), .mem_data_i(mem_data_i), .mem_we_i(mem_we_i),
        .mem_op_i(mem_op_i),
        .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
        .bus_wdata_o(bus_wdata_o), .bus_be_o(bus_be_o),
        .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i),
        .reg_waddr_o(reg_waddr_o), .reg_we_o(reg_we_o), .reg_wdata_o(reg_wdata_o),
        .stallreq_o(stallreq_o), .misalign_o(misalign_o), .timeout_o(timeout_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic is_load(input logic [3:0] op);
        return (op >= OP_LB) && (op <= OP_LHU);
    endfunction

    function automatic logic [3:0] model_be(input logic [3:0] op, input logic [1:0] lo);
        case (op)
            OP_LB, OP_LBU, OP_SB: return (lo == 2'd0) ? 4'h1 : (lo == 2'd1) ? 4'h2 :
                                         (lo == 2'd2) ? 4'h4 : 4'h8;
            OP_LH, OP_LHU, OP_SH: return lo[1] ? 4'hC : 4'h3;
            default:              return 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] model_wdata(input logic [3:0] op, input logic [31:0] d);
        case (op)
            OP_SB:   return d[7:0] * 32'h01010101;
            OP_SH:   return d[15:0] * 32'h00010001;
            OP_SW:   return d;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] model_load(input logic [3:0] op, input logic [1:0] lo,
                                               input logic [31:0] w);
        logic [31:0] b, h;
        b = w >> {lo, 3'b000};
        h = w >> {lo[1], 4'b0000};
        case (op)
            OP_LB:   return {{24{b[7]}}, b[7:0]};
            OP_LBU:  return b & 32'hFF;
            OP_LH:   return {{16{h[15]}}, h[15:0]};
            OP_LHU:  return h & 32'hFFFF;
            default: return w;
        endcase
    endfunction

    task automatic chk_all_zero(input string pfx);
        chk({pfx, "_bus_req"}, {31'd0, bus_req_o}, 32'd0);
        chk({pfx, "_bus_we"}, {31'd0, bus_we_o}, 32'd0);
        chk({pfx, "_bus_addr"}, bus_addr_o, 32'd0);
        chk({pfx, "_bus_wdata"}, bus_wdata_o, 32'd0);
        chk({pfx, "_bus_be"}, {28'd0, bus_be_o}, 32'd0);
        chk({pfx, "_reg_waddr"}, {27'd0, reg_waddr_o}, 32'd0);
        chk({pfx, "_reg_we"}, {31'd0, reg_we_o}, 32'd0);
        chk({pfx, "_reg_wdata"}, reg_wdata_o, 32'd0);
        chk({pfx, "_misalign"}, {31'd0, misalign_o}, 32'd0);
        chk({pfx, "_timeout"}, {31'd0, timeout_o}, 32'd0);
    endtask

    task automatic drive_nop();
        mem_op_i = OP_NOP; reg_we_i = 1'b0; reg_waddr_i = 5'd0; reg_wdata_i = 32'd0;
        mem_addr_i = 32'd0; mem_data_i = 32'd0; mem_we_i = 1'b0;
    endtask

    // Present an aligned op for one cycle and check the bus outputs after the issue edge.
    task automatic issue(input logic [3:0] op, input logic [31:0] addr,
                         input logic [31:0] data, input logic [4:0] dest);
        mem_op_i = op; mem_addr_i = addr; mem_data_i = data; reg_waddr_i = dest;
        mem_we_i = (op >= OP_SB);
        #1;
        chk("issue_stall", {31'd0, stallreq_o}, 32'd1);
        cur_op = op; cur_addr = addr; cur_dest = dest;
        @(posedge clk_i); #1;
        drive_nop();
        chk("issue_req", {31'd0, bus_req_o}, 32'd1);
        chk("issue_we", {31'd0, bus_we_o}, {31'd0, (op >= OP_SB)});
        chk("issue_addr", bus_addr_o, {addr[31:2], 2'b00});
        chk("issue_be", {28'd0, bus_be_o}, {28'd0, model_be(op, addr[1:0])});
        chk("issue_wdata", bus_wdata_o, model_wdata(op, data));
        chk("issue_reg_we", {31'd0, reg_we_o}, 32'd0);
    endtask

    // Hold the bus nwait cycles, then ack with rdata and check writeback against the scoreboard.
    task automatic wait_ack(input int nwait, input logic [31:0] rdata);
        wb_t e;
        logic [31:0] held_addr;
        held_addr = bus_addr_o;
        for (int i = 0; i < nwait; i++) begin
            chk("bus_stall", {31'd0, stallreq_o}, 32'd1);
            chk("bus_req_held", {31'd0, bus_req_o}, 32'd1);
            chk("bus_addr_held", bus_addr_o, held_addr);
            chk("bus_reg_we", {31'd0, reg_we_o}, 32'd0);
            @(posedge clk_i); #1;
        end
        bus_ack_i = 1'b1; bus_rdata_i = rdata;
        if (is_load(cur_op)) begin
            e.waddr = cur_dest;
            e.wdata = model_load(cur_op, cur_addr[1:0], rdata);
            sb_q.push_back(e);
        end
        #1;
        chk("ack_stall", {31'd0, stallreq_o}, 32'd0);
        @(posedge clk_i); #1;
        bus_ack_i = 1'b0; bus_rdata_i = 32'd0;
        chk("done_req", {31'd0, bus_req_o}, 32'd0);
        chk("done_timeout", {31'd0, timeout_o}, 32'd0);
        chk("done_reg_we", {31'd0, reg_we_o}, {31'd0, is_load(cur_op)});
        if (reg_we_o === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_wb", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk("wb_waddr", {27'd0, reg_waddr_o}, {27'd0, e.waddr});
                chk("wb_wdata", reg_wdata_o, e.wdata);
            end
        end
        @(posedge clk_i); #1;
        chk("wb_pulse_end", {31'd0, reg_we_o}, 32'd0);
    endtask

    initial begin
        rst_i = 1'b1; bus_ack_i = 1'b0; bus_rdata_i = 32'd0;
        cur_op = OP_NOP; cur_addr = 32'd0; cur_dest = 5'd0;
        drive_nop();
        repeat (2) @(posedge clk_i);
        #1;
        chk_all_zero("reset");
        chk("reset_stall", {31'd0, stallreq_o}, 32'd0);
        rst_i = 1'b0;
        @(posedge clk_i); #1;

        // NOP pass-through
        reg_waddr_i = 5'd5; reg_we_i = 1'b1; reg_wdata_i = 32'h1234;
        #1;
        chk("nop_stall", {31'd0, stallreq_o}, 32'd0);
        @(posedge clk_i); #1;
        chk("nop_waddr", {27'd0, reg_waddr_o}, 32'd5);
        chk("nop_we", {31'd0, reg_we_o}, 32'd1);
        chk("nop_wdata", reg_wdata_o, 32'h1234);
        chk("nop_bus_req", {31'd0, bus_req_o}, 32'd0);
        chk("nop_stall2", {31'd0, stallreq_o}, 32'd0);
        drive_nop();
        @(posedge clk_i); #1;

        // Stores and loads
        issue(OP_SB, 32'h1003, 32'h000000AB, 5'd0);
        wait_ack(2, 32'h0);
        issue(OP_SH, 32'h1002, 32'h00001234, 5'd0);
        wait_ack(0, 32'h0);
        issue(OP_LB, 32'h2002, 32'h0, 5'd7);
        wait_ack(1, 32'h0080FF00);
        issue(OP_LBU, 32'h2002, 32'h0, 5'd8);
        wait_ack(1, 32'h0080FF00);
        issue(OP_LH, 32'h2002, 32'h0, 5'd9);
        wait_ack(1, 32'h0080FF00);
        issue(OP_LHU, 32'h2000, 32'h0, 5'd10);
        wait_ack(0, 32'h1234_9ABC);
        issue(OP_LW, 32'h2004, 32'h0, 5'd0);
        wait_ack(2, 32'hDEAD_BEEF);

        // Misaligned word load is dropped
        mem_op_i = OP_LW; mem_addr_i = 32'h3001; reg_waddr_i = 5'd3;
        #1;
        chk("mis_stall", {31'd0, stallreq_o}, 32'd0);
        @(posedge clk_i); #1;
        drive_nop();
        chk("mis_pulse", {31'd0, misalign_o}, 32'd1);
        chk("mis_bus_req", {31'd0, bus_req_o}, 32'd0);
        chk("mis_reg_we", {31'd0, reg_we_o}, 32'd0);
        @(posedge clk_i); #1;
        chk("mis_pulse_end", {31'd0, misalign_o}, 32'd0);

        // Timeout with no ack: request held for counter 0..4
        issue(OP_SW, 32'h4000, 32'hCAFEF00D, 5'd0);
        for (int i = 0; i < 5; i++) begin
            chk("tmo_req_held", {31'd0, bus_req_o}, 32'd1);
            chk("tmo_stall", {31'd0, stallreq_o}, (i < 4) ? 32'd1 : 32'd0);
            chk("tmo_no_pulse", {31'd0, timeout_o}, 32'd0);
            @(posedge clk_i); #1;
        end
        chk("tmo_pulse", {31'd0, timeout_o}, 32'd1);
        chk("tmo_req_drop", {31'd0, bus_req_o}, 32'd0);
        chk("tmo_reg_we", {31'd0, reg_we_o}, 32'd0);
        chk("tmo_idle_stall", {31'd0, stallreq_o}, 32'd0);
        @(posedge clk_i); #1;
        chk("tmo_pulse_end", {31'd0, timeout_o}, 32'd0);

        // Ack on the final counter value completes normally
        issue(OP_LW, 32'h4008, 32'h0, 5'd12);
        wait_ack(4, 32'h0BAD_F00D);

        // Reset in the middle of a bus transaction
        issue(OP_LW, 32'h5000, 32'h0, 5'd13);
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        chk_all_zero("midrst");
        chk("midrst_stall", {31'd0, stallreq_o}, 32'd0);
        rst_i = 1'b0;
        bus_ack_i = 1'b1; bus_rdata_i = 32'h5555_AAAA;
        #1;
        chk("post_rst_stall", {31'd0, stallreq_o}, 32'd0);
        @(posedge clk_i); #1;
        bus_ack_i = 1'b0; bus_rdata_i = 32'd0;
        chk("post_rst_reg_we", {31'd0, reg_we_o}, 32'd0);
        chk("post_rst_bus_req", {31'd0, bus_req_o}, 32'd0);
        chk("sb_empty", sb_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- Memory-access stage directly downstream of the execute stage.
- Consumes execute's writeback triple (reg_waddr/reg_we/reg_wdata) and memory request (mem_addr/mem_data/mem_we/mem_op).
- Performs loads and stores over a req/ack word bus with byte enables, sign/zero-extends load data and presents registered writeback to the write-back stage.
- Asserts stallreq_o to hold the upstream pipeline while a bus transaction is outstanding.

Parameters:
DATA_WIDTH, 32, data/bus width
ADDR_WIDTH, 32, byte address width
TIMEOUT_CYCLES, 255, max cycles in BUS without ack before abort (fits 8-bit counter)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
reg_waddr_i  in  5  dest register from execute
reg_we_i  in  1  write enable from execute
reg_wdata_i  in  32  ALU result from execute
mem_addr_i  in  32  byte address
mem_data_i  in  32  store data
mem_we_i  in  1  store indicator
mem_op_i  in  4  MEM_NOP=0 LB=1 LH=2 LW=3 LBU=4 LHU=5 SB=6 SH=7 SW=8
bus_req_o  out  1  transaction request
bus_we_o  out  1  1=write
bus_addr_o  out  32  word-aligned address {addr[31:2],2'b00}
bus_wdata_o  out  32  lane-placed store data
bus_be_o  out  4  byte enables
bus_ack_i  in  1  transaction complete; rdata valid same cycle
bus_rdata_i  in  32  read word
reg_waddr_o  out  5  registered dest register
reg_we_o  out  1  registered write enable
reg_wdata_o  out  32  registered writeback data
stallreq_o  out  1  combinational hold request to upstream
misalign_o  out  1  one-cycle pulse: misaligned access dropped
timeout_o  out  1  one-cycle pulse: bus transaction aborted

Behaviour:
- Clock clk_i; reset rst_i is synchronous and active-high. On reset: state IDLE, counter 0, every output register 0 (bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_be_o, reg_*_o, misalign_o, timeout_o). An ack arriving after reset is ignored.
- Mem op = mem_op_i in 1..8; any other value is treated as NOP.
- Misaligned accesses:
  - LH/LHU/SH with addr[0]=1.
  - LW/SW with addr[1:0]!=0.
- States: IDLE, BUS.
- IDLE, NOP: next edge reg_*_o <= reg_*_i (1-cycle pass-through latency). stallreq_o=0.
- IDLE, misaligned op: no bus activity, stallreq_o=0. Next edge: reg_we_o<=0 and misalign_o<=1 for one cycle.
- IDLE, aligned op: stallreq_o=1 combinationally. Next edge:
  - Latch op, addr[1:0] and dest register.
  - Drive bus_req_o=1, bus_addr_o, bus_we_o=(op is store), bus_be_o and bus_wdata_o.
  - Clear counter; reg_we_o<=0 (bubble); state BUS.
- Lane placement:
  - SB: be=4'b0001<<addr[1:0], wdata={4{data[7:0]}}.
  - SH: be=addr[1]?4'b1100:4'b0011, wdata={2{data[15:0]}}.
  - SW: be=4'b1111, wdata=data.
  - Loads: be per same rule, wdata=0.
- BUS: bus signals held stable until the exit edge. stallreq_o = !bus_ack_i && counter!=TIMEOUT_CYCLES. Each cycle: reg_we_o<=0; counter increments.
- Ack in BUS: next edge bus_req_o<=0, state IDLE.
  - Load: reg_we_o<=1, reg_waddr_o<=latched dest, reg_wdata_o<=extracted data.
  - Store: reg_we_o<=0.
  - Upstream advances on the same edge, since stallreq_o is low that cycle.
- Load extraction: byte/half selected by latched addr[1:0]. LB/LH sign-extend; LBU/LHU zero-extend; LW takes the full word.
- Timeout: counter==TIMEOUT_CYCLES with no ack. Next edge bus_req_o<=0, timeout_o<=1 for one cycle, reg_we_o<=0, state IDLE. Ack and timeout in the same cycle: ack wins.
- Load to x0 passes through unchanged; the register file discards it.

Decomposition:
- mem_op encodings, bus-width and timeout-counter-width constants belong in the shared defines.
- One combinational sub-module, mem_lane, handles store lane placement/byte-enable generation and load extraction/extension. mem_access holds the FSM, counter and registers.

Test Plan:
- NOP pass-through: reg_waddr_i=5, reg_we_i=1, reg_wdata_i=0x1234 -> next cycle reg_*_o match; stallreq_o never high; bus_req_o=0.
- SB to 0x1003, data 0x000000AB -> bus_addr_o=0x1000, be=4'b1000, wdata=0xABABABAB. With ack after 3 cycles: stallreq_o high 3 cycles, then low in the ack cycle; reg_we_o=0 throughout.
- LB from 0x2002, rdata 0x0080FF00, ack after 1 cycle -> reg_wdata_o=0xFFFFFF80, reg_we_o=1 one cycle after ack. Same with LBU -> 0x00000080. LH from 0x2002 -> 0x00000080.
- LW from 0x3001 -> misalign_o pulses 1 cycle, bus_req_o stays 0, reg_we_o=0, no stall.
- TIMEOUT_CYCLES=4, SW with ack never asserted -> bus_req_o high 5 cycles, timeout_o pulses, FSM in IDLE, stallreq_o drops. Ack arriving on the counter==4 cycle -> normal completion, no timeout_o.
- rst_i asserted mid-BUS -> next cycle all outputs 0, state IDLE; a subsequent ack produces no writeback.
